// File: rtl/cdc_2phase_rx.sv
// cdc_2phase_rx
//   Receiving half of a 2-phase (toggle) req/ack clock-domain crossing.
//   The foreign-domain request is synchronised into clk_i. The bundled data
//   is captured once the synchronised request phase differs from the local
//   ack phase. The captured word is then offered as a valid/ready stream.
//
// Parameters
//   T            payload type (async_data_i held stable by sender while req != ack)
//   SYNC_STAGES  synchroniser depth on async_req_i, must be >= 2
//
// Ports
//   clk_i         receive-domain clock
//   rst_i         synchronous active-high reset
//   async_req_i   2-phase request; each toggle announces one new word
//   async_data_i  bundled data from the foreign domain
//   async_ack_o   2-phase acknowledge, straight from a flop
//   dst_data_o    received word (oldest buffered entry)
//   dst_valid_o   dst_data_o holds an unconsumed word
//   dst_ready_i   consumer accepts the word on valid && ready
//
// Configuration
//   CDC_2PHASE_RX_SPILL_EN  defined   : two-entry buffer, ack toggles on capture
//                           undefined : single register, ack toggles on consume
module cdc_2phase_rx #(
    parameter type         T           = logic [7:0],
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_req_i,
    input  T     async_data_i,
    output logic async_ack_o,
    output T     dst_data_o,
    output logic dst_valid_o,
    input  logic dst_ready_i
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("cdc_2phase_rx: SYNC_STAGES must be >= 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   pending;
    logic                   ack_q, ack_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_req_i};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];
    // Phase compare rather than edge detect: the request stays pending until
    // the local ack catches up, so a word can never be dropped or taken twice.
    assign pending     = req_s ^ ack_q;
    assign async_ack_o = ack_q;

`ifdef CDC_2PHASE_RX_SPILL_EN

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_e;

    state_e state_q, state_d;
    T       head_q, head_d;
    T       tail_q, tail_d;
    logic   capture;
    logic   consume;

    assign consume = (state_q != EMPTY) && dst_ready_i;
    // Acknowledge as soon as the word sits in the buffer, so the sender can
    // start the next round trip while the consumer still holds the previous word.
    assign capture = pending && (state_q != TWO);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            ack_q   <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (capture) begin
            ack_d = ~ack_q;
        end
        unique case (state_q)
            EMPTY: begin
                if (capture) begin
                    head_d  = async_data_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                unique case ({capture, consume})
                    2'b11: head_d = async_data_i;
                    2'b10: begin
                        tail_d  = async_data_i;
                        state_d = TWO;
                    end
                    2'b01: state_d = EMPTY;
                    default: ;
                endcase
            end
            TWO: begin
                if (consume) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign dst_valid_o = (state_q != EMPTY);
    assign dst_data_o  = head_q;

`else

    typedef enum logic {
        EMPTY,
        FULL
    } state_e;

    state_e state_q, state_d;
    T       data_q, data_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            ack_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        data_d  = data_q;
        unique case (state_q)
            EMPTY: begin
                if (pending) begin
                    data_d  = async_data_i;
                    state_d = FULL;
                end
            end
            FULL: begin
                // Ack only on consume: the sender cannot present a new word
                // before this toggle, so a pending request in FULL is ignored.
                if (dst_ready_i) begin
                    ack_d   = ~ack_q;
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign dst_valid_o = (state_q == FULL);
    assign dst_data_o  = data_q;

`endif

endmodule

// File: tb/tb_cdc_2phase_rx.sv
`timescale 1ns/1ps
module tb_cdc_2phase_rx;

`ifdef CDC_2PHASE_RX_SPILL_EN
    localparam bit SPILL = 1'b1;
`else
    localparam bit SPILL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       sclk = 1'b0;
    int         sper = 5;
    logic       rst_i;
    logic       async_req_i;
    logic [7:0] async_data_i;
    logic       async_ack_o;
    logic [7:0] dst_data_o;
    logic       dst_valid_o;
    logic       dst_ready_i;

    int         n_cmp = 0;
    int         n_err = 0;
    int         req_tog = 0;
    int         ack_tog = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always #(sper) sclk = ~sclk;
    always @(async_ack_o) ack_tog++;

    cdc_2phase_rx #(
        .T(logic [7:0]),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .async_req_i(async_req_i),
        .async_data_i(async_data_i),
        .async_ack_o(async_ack_o),
        .dst_data_o(dst_data_o),
        .dst_valid_o(dst_valid_o),
        .dst_ready_i(dst_ready_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic v);
        int w = 0;
        while (async_ack_o !== v && w < 20) begin
            tick();
            w++;
        end
        check("wait_ack", async_ack_o, v);
    endtask

    // Ideal foreign-domain sender: new word as soon as ack matches req.
    task automatic sender(input int n);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            @(posedge sclk);
            while (async_ack_o !== async_req_i && w < 2000) begin
                @(posedge sclk);
                w++;
            end
            if (w >= 2000) begin
                check("snd_ack_wait", async_ack_o, async_req_i);
                break;
            end
            async_data_i = 8'($urandom);
            exp_q.push_back(async_data_i);
            async_req_i = ~async_req_i;
            req_tog++;
        end
    endtask

    task automatic consumer(input int n, input bit rnd);
        int         got = 0;
        int         idle = 0;
        logic       pv = 1'b0;
        logic       pr = 1'b0;
        logic [7:0] pd = '0;
        while (got < n && idle < 500) begin
            @(negedge clk);
            idle++;
            if (pv && !pr) begin
                check("axis_hold_valid", dst_valid_o, 1);
                check("axis_hold_data", dst_data_o, pd);
            end
            check("ack_le_req", (ack_tog <= req_tog), 1);
            dst_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (dst_valid_o && dst_ready_i) begin
                check("word_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("word", dst_data_o, exp_q.pop_front());
                    got++;
                    idle = 0;
                end
            end
            pv = dst_valid_o;
            pr = dst_ready_i;
            pd = dst_data_o;
        end
        check("rx_count", got, n);
        @(posedge clk);
        #1;
        dst_ready_i = 1'b0;
    endtask

    task automatic run_stream(input int n, input bit rnd);
        int w = 0;
        sper    = $urandom_range(2, 15);
        req_tog = 0;
        ack_tog = 0;
        fork
            sender(n);
            consumer(n, rnd);
        join
        while (async_ack_o !== async_req_i && w < 100) begin
            tick();
            w++;
        end
        check("drain_ack", async_ack_o, async_req_i);
        check("tog_count", ack_tog, req_tog);
        check("req_count", req_tog, n);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] got_w[3];
        int         k;
        int         w;

        rst_i        = 1'b1;
        async_req_i  = 1'b0;
        async_data_i = '0;
        dst_ready_i  = 1'b0;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        check("rst_valid", dst_valid_o, 0);
        check("rst_ack", async_ack_o, 0);
        check("rst_data", dst_data_o, 8'h00);

        // Single word with backpressure: latency, hold, ack
        async_data_i = 8'hA5;
        async_req_i  = 1'b1;
        tick();
        check("lat_e1_valid", dst_valid_o, 0);
        tick();
        check("lat_e2_valid", dst_valid_o, 0);
        tick();
        check("lat_e3_valid", dst_valid_o, 1);
        check("lat_e3_data", dst_data_o, 8'hA5);
        check("lat_e3_ack", async_ack_o, SPILL ? 1 : 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", dst_valid_o, 1);
            check("bp_data", dst_data_o, 8'hA5);
            check("bp_ack", async_ack_o, SPILL ? 1 : 0);
        end
        dst_ready_i = 1'b1;
        tick();
        check("bp_rel_ack", async_ack_o, 1);
        check("bp_rel_valid", dst_valid_o, 0);
        dst_ready_i = 1'b0;

        // Second word, ready already high, req 1->0
        async_data_i = 8'h5A;
        async_req_i  = 1'b0;
        dst_ready_i  = 1'b1;
        tick();
        tick();
        check("w2_e2_valid", dst_valid_o, 0);
        tick();
        check("w2_e3_valid", dst_valid_o, 1);
        check("w2_e3_data", dst_data_o, 8'h5A);
        check("w2_e3_ack", async_ack_o, SPILL ? 0 : 1);
        tick();
        check("w2_e4_valid", dst_valid_o, 0);
        check("w2_e4_ack", async_ack_o, 0);
        dst_ready_i = 1'b0;

        // Reset while a word is held, req high
        async_data_i = 8'hC3;
        async_req_i  = 1'b1;
        repeat (3) tick();
        check("pre_rst_valid", dst_valid_o, 1);
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i       = 1'b0;
        async_req_i = 1'b0;
        tick();
        check("mid_rst_valid", dst_valid_o, 0);
        check("mid_rst_ack", async_ack_o, 0);
        check("mid_rst_data", dst_data_o, 8'h00);
        repeat (5) tick();
        check("mid_rst_idle", dst_valid_o, 0);

`ifdef CDC_2PHASE_RX_SPILL_EN
        // Two words buffered under backpressure, third left pending
        async_data_i = 8'h11;
        async_req_i  = 1'b1;
        wait_ack(1'b1);
        async_data_i = 8'h22;
        async_req_i  = 1'b0;
        wait_ack(1'b0);
        async_data_i = 8'h33;
        async_req_i  = 1'b1;
        repeat (10) tick();
        check("spill_third_pending", async_ack_o, 0);
        check("spill_valid", dst_valid_o, 1);
        check("spill_head", dst_data_o, 8'h11);
        dst_ready_i = 1'b1;
        k = 0;
        w = 0;
        while (k < 3 && w < 20) begin
            if (dst_valid_o) begin
                got_w[k] = dst_data_o;
                k++;
            end
            tick();
            w++;
        end
        check("spill_cnt", k, 3);
        check("spill_ord0", got_w[0], 8'h11);
        check("spill_ord1", got_w[1], 8'h22);
        check("spill_ord2", got_w[2], 8'h33);
        check("spill_ack_end", async_ack_o, 1);
        dst_ready_i = 1'b0;
        tick();
`endif

        // 256-word stream over four random clock ratios, random backpressure
        for (int c = 0; c < 4; c++) begin
            run_stream(64, 1'b1);
        end

        // Phase wrap: 1000 back-to-back toggles, consumer always ready
        run_stream(1000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
